// File: rtl/router_ctrl.sv
// -----------------------------------------------------------------------------
// router_ctrl
// Control FSM for a 1-to-3 packet router. A packet arrives as a header byte
// (destination in data_in[1:0]), payload bytes while pkt_valid=1, and a parity
// byte on the cycle pkt_valid drops. The FSM steers write strobes to the
// output FIFO at the latched address, stalls the source (busy) while it waits
// for space, and flushes any FIFO that sits unread for 30 cycles.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous active-high reset, overrides every input
//   pkt_valid    in   high for header and payload bytes, low on parity byte
//   data_in[7:0] in   source byte; [1:0] is the destination on the header
//   fifo_full    in   per-FIFO full flags
//   fifo_empty   in   per-FIFO empty flags
//   read_enb     in   per-FIFO downstream read strobes
//   write_enb    out  one-hot write strobe to the addressed FIFO
//   detect_add, lfd_state, ld_state, laf_state, rst_int_reg
//                out  state-decode strobes for the datapath
//   busy         out  source must hold data_in while high
//   vld_out      out  per-FIFO data-available (= ~fifo_empty)
//   soft_reset   out  registered one-cycle timeout flush per FIFO
// -----------------------------------------------------------------------------
module router_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS  = 3'd0,
    WAIT_TILL_EMPTY = 3'd1,
    LOAD_FIRST_DATA = 3'd2,
    LOAD_DATA       = 3'd3,
    FIFO_FULL_STATE = 3'd4,
    LOAD_AFTER_FULL = 3'd5,
    LOAD_PARITY     = 3'd6,
    CHECK_PARITY    = 3'd7
  } state_e;

  // Idle cycles before a flush fires: counter reaches 29 after 29 idle
  // cycles, so the pulse appears after the 30th idle edge.
  localparam logic [4:0] IDLE_TERMINAL = 5'd29;

  state_e     state_r;
  state_e     next_state_s;
  logic [1:0] addr_r;
  logic [4:0] idle_cnt_r [3];
  logic [2:0] soft_reset_r;

  logic [1:0] hdr_addr_s;
  logic       hdr_ok_s;
  logic       full_q_s;
  logic       empty_q_s;
  logic       abort_s;
  logic [2:0] we_s;
  logic [2:0] we_raw_s;
  logic       detect_add_s;
  logic       lfd_s;
  logic       ld_s;
  logic       laf_s;
  logic       rst_int_s;
  logic       busy_s;
  logic [2:0] vld_s;
  logic       unused_s;

  // Select bit idx of a 3-bit per-FIFO vector; address 3 has no FIFO.
  function automatic logic sel3(input logic [2:0] vec, input logic [1:0] idx);
    logic bit_v;
    case (idx)
      2'd0:    bit_v = vec[0];
      2'd1:    bit_v = vec[1];
      2'd2:    bit_v = vec[2];
      default: bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

  // One-hot decode of a FIFO address; address 3 decodes to no strobe.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh_v;
    case (idx)
      2'd0:    oh_v = 3'b001;
      2'd1:    oh_v = 3'b010;
      2'd2:    oh_v = 3'b100;
      default: oh_v = 3'b000;
    endcase
    return oh_v;
  endfunction

  assign hdr_addr_s = data_in[1:0];
  assign hdr_ok_s   = pkt_valid && (hdr_addr_s != 2'd3);
  assign full_q_s   = sel3(fifo_full, addr_r);
  assign empty_q_s  = sel3(fifo_empty, addr_r);
  assign vld_s      = ~fifo_empty;
  // A timeout on the FIFO being written kills the packet in flight.
  assign abort_s    = sel3(soft_reset_r, addr_r) && (state_r != DECODE_ADDRESS);
  assign unused_s   = ^data_in[7:2];

  // State register and destination-address latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= DECODE_ADDRESS;
      addr_r  <= 2'd0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == DECODE_ADDRESS) && hdr_ok_s) begin
        addr_r <= hdr_addr_s;
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  // Next-state logic and state-decode outputs.
  always_comb begin
    next_state_s = state_r;
    we_raw_s     = 3'b000;
    we_s         = 3'b000;
    detect_add_s = 1'b0;
    lfd_s        = 1'b0;
    ld_s         = 1'b0;
    laf_s        = 1'b0;
    rst_int_s    = 1'b0;
    busy_s       = 1'b0;

    case (state_r)
      DECODE_ADDRESS: begin
        detect_add_s = 1'b1;
        if (hdr_ok_s) begin
          if (sel3(fifo_empty, hdr_addr_s)) begin
            next_state_s = LOAD_FIRST_DATA;
          end else begin
            next_state_s = WAIT_TILL_EMPTY;
          end
        end else begin
          next_state_s = DECODE_ADDRESS;
        end
      end
      WAIT_TILL_EMPTY: begin
        busy_s = 1'b1;
        if (empty_q_s) begin
          next_state_s = LOAD_FIRST_DATA;
        end else begin
          next_state_s = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: begin
        lfd_s        = 1'b1;
        busy_s       = 1'b1;
        we_raw_s     = onehot3(addr_r);
        next_state_s = LOAD_DATA;
      end
      LOAD_DATA: begin
        ld_s = 1'b1;
        if (pkt_valid) begin
          we_raw_s = onehot3(addr_r);
        end else begin
          we_raw_s = 3'b000;
        end
        if (full_q_s) begin
          next_state_s = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          next_state_s = LOAD_PARITY;
        end else begin
          next_state_s = LOAD_DATA;
        end
      end
      FIFO_FULL_STATE: begin
        busy_s = 1'b1;
        if (!full_q_s) begin
          next_state_s = LOAD_AFTER_FULL;
        end else begin
          next_state_s = FIFO_FULL_STATE;
        end
      end
      LOAD_AFTER_FULL: begin
        laf_s    = 1'b1;
        busy_s   = 1'b1;
        we_raw_s = onehot3(addr_r);
        if (pkt_valid) begin
          next_state_s = LOAD_DATA;
        end else begin
          next_state_s = LOAD_PARITY;
        end
      end
      LOAD_PARITY: begin
        busy_s       = 1'b1;
        we_raw_s     = onehot3(addr_r);
        next_state_s = CHECK_PARITY;
      end
      CHECK_PARITY: begin
        rst_int_s    = 1'b1;
        busy_s       = 1'b1;
        next_state_s = DECODE_ADDRESS;
      end
      default: begin
        next_state_s = DECODE_ADDRESS;
      end
    endcase

    // Abort wins over everything; otherwise a full FIFO is never written.
    if (abort_s) begin
      next_state_s = DECODE_ADDRESS;
      we_s         = 3'b000;
    end else if (full_q_s) begin
      we_s = 3'b000;
    end else begin
      we_s = we_raw_s;
    end
  end

  // Per-FIFO idle counters and registered timeout flush pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        idle_cnt_r[i]   <= 5'd0;
        soft_reset_r[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (read_enb[i] || !vld_s[i]) begin
          // A read in the terminal cycle cancels the flush.
          idle_cnt_r[i]   <= 5'd0;
          soft_reset_r[i] <= 1'b0;
        end else if (idle_cnt_r[i] == IDLE_TERMINAL) begin
          idle_cnt_r[i]   <= 5'd0;
          soft_reset_r[i] <= 1'b1;
        end else begin
          idle_cnt_r[i]   <= idle_cnt_r[i] + 5'd1;
          soft_reset_r[i] <= 1'b0;
        end
      end
    end
  end

  assign write_enb   = we_s;
  assign detect_add  = detect_add_s;
  assign lfd_state   = lfd_s;
  assign ld_state    = ld_s;
  assign laf_state   = laf_s;
  assign rst_int_reg = rst_int_s;
  assign busy        = busy_s;
  assign vld_out     = vld_s;
  assign soft_reset  = soft_reset_r;

endmodule

// File: tb/tb_router_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_ctrl
// Directed, self-checking bench for router_ctrl. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge. The packed
// observation word is {detect_add, lfd, ld, laf, rst_int, busy, write_enb}.
// -----------------------------------------------------------------------------
module tb_router_ctrl;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [2:0] write_enb;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       rst_int_reg;
  logic       busy;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  logic [8:0] obs;
  int checks;
  int errors;

  // Expected observation words
  localparam logic [8:0] O_DEC  = 9'b1_0_0_0_0_0_000;
  localparam logic [8:0] O_WAIT = 9'b0_0_0_0_0_1_000;
  localparam logic [8:0] O_FULL = 9'b0_0_0_0_0_1_000;
  localparam logic [8:0] O_CP   = 9'b0_0_0_0_1_1_000;

  router_ctrl dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .write_enb(write_enb), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .busy(busy), .vld_out(vld_out), .soft_reset(soft_reset)
  );

  assign obs = {detect_add, lfd_state, ld_state, laf_state, rst_int_reg, busy, write_enb};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    @(negedge clock);
    checks++;
    if (obs !== O_DEC) begin
      errors++; $display("FAIL reset_strobes got=%b exp=%b", obs, O_DEC);
    end
    checks++;
    if (soft_reset !== 3'b000) begin
      errors++; $display("FAIL reset_soft got=%b exp=%b", soft_reset, 3'b000);
    end
    fifo_empty = 3'b010;
    #1;
    checks++;
    if (vld_out !== 3'b101) begin
      errors++; $display("FAIL vld_out got=%b exp=%b", vld_out, 3'b101);
    end
    fifo_empty = 3'b111;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic_packet();
    int nwr;
    logic [8:0] exp_v [7];
    logic       pv_v  [7];
    exp_v[0] = O_DEC;                   pv_v[0] = 1'b1;
    exp_v[1] = 9'b0_1_0_0_0_1_010;      pv_v[1] = 1'b1;
    exp_v[2] = 9'b0_0_1_0_0_0_010;      pv_v[2] = 1'b1;
    exp_v[3] = 9'b0_0_1_0_0_0_010;      pv_v[3] = 1'b1;
    exp_v[4] = 9'b0_0_1_0_0_0_010;      pv_v[4] = 1'b1;
    exp_v[5] = 9'b0_0_1_0_0_0_000;      pv_v[5] = 1'b0;
    exp_v[6] = 9'b0_0_0_0_0_1_010;      pv_v[6] = 1'b0;
    nwr = 0;
    for (int k = 0; k < 7; k++) begin
      pkt_valid = pv_v[k];
      data_in   = (k == 0) ? 8'h05 : 8'hA0 + 8'(k);
      @(negedge clock);
      checks++;
      if (obs !== exp_v[k]) begin
        errors++; $display("FAIL basic_step%0d got=%b exp=%b", k, obs, exp_v[k]);
      end
      if (write_enb == 3'b010) nwr++;
      cyc();
    end
    @(negedge clock);
    checks++;
    if (obs !== O_CP) begin
      errors++; $display("FAIL basic_check_parity got=%b exp=%b", obs, O_CP);
    end
    cyc();
    @(negedge clock);
    checks++;
    if (obs !== O_DEC) begin
      errors++; $display("FAIL basic_back_to_decode got=%b exp=%b", obs, O_DEC);
    end
    checks++;
    if (nwr !== 5) begin
      errors++; $display("FAIL basic_write_count got=%0d exp=%0d", nwr, 5);
    end
  endtask

  task automatic test_wait_empty();
    fifo_empty = 3'b011;
    pkt_valid  = 1'b1;
    data_in    = 8'h02;
    cyc();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) fifo_empty = 3'b111;
      @(negedge clock);
      checks++;
      if (obs !== O_WAIT) begin
        errors++; $display("FAIL wait_hold%0d got=%b exp=%b", k, obs, O_WAIT);
      end
      cyc();
    end
    @(negedge clock);
    checks++;
    if (obs !== 9'b0_1_0_0_0_1_100) begin
      errors++; $display("FAIL wait_lfd got=%b exp=%b", obs, 9'b0_1_0_0_0_1_100);
    end
    cyc();
    pkt_valid = 1'b0;
    cyc();
    @(negedge clock);
    checks++;
    if (obs !== 9'b0_0_0_0_0_1_100) begin
      errors++; $display("FAIL wait_parity got=%b exp=%b", obs, 9'b0_0_0_0_0_1_100);
    end
    cyc();
    cyc();
  endtask

  task automatic test_fifo_full();
    pkt_valid = 1'b1;
    data_in   = 8'h00;
    cyc();
    @(negedge clock);
    checks++;
    if (obs !== 9'b0_1_0_0_0_1_001) begin
      errors++; $display("FAIL full_lfd got=%b exp=%b", obs, 9'b0_1_0_0_0_1_001);
    end
    cyc();
    fifo_full = 3'b001;
    @(negedge clock);
    checks++;
    if (obs !== 9'b0_0_1_0_0_0_000) begin
      errors++; $display("FAIL full_ld_blocked got=%b exp=%b", obs, 9'b0_0_1_0_0_0_000);
    end
    cyc();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) fifo_full = 3'b000;
      @(negedge clock);
      checks++;
      if (obs !== O_FULL) begin
        errors++; $display("FAIL full_stall%0d got=%b exp=%b", k, obs, O_FULL);
      end
      cyc();
    end
    @(negedge clock);
    checks++;
    if (obs !== 9'b0_0_0_1_0_1_001) begin
      errors++; $display("FAIL full_laf got=%b exp=%b", obs, 9'b0_0_0_1_0_1_001);
    end
    cyc();
    @(negedge clock);
    checks++;
    if (obs !== 9'b0_0_1_0_0_0_001) begin
      errors++; $display("FAIL full_resume got=%b exp=%b", obs, 9'b0_0_1_0_0_0_001);
    end
    pkt_valid = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask

  task automatic test_timeout();
    logic [2:0] exp_sr;
    fifo_empty = 3'b011;
    read_enb   = 3'b000;
    for (int k = 1; k <= 31; k++) begin
      cyc();
      @(negedge clock);
      exp_sr = (k == 30) ? 3'b100 : 3'b000;
      checks++;
      if (soft_reset !== exp_sr) begin
        errors++; $display("FAIL timeout_edge%0d got=%b exp=%b", k, soft_reset, exp_sr);
      end
    end
    read_enb = 3'b100;
    cyc();
    read_enb = 3'b000;
    for (int k = 1; k <= 29; k++) begin
      cyc();
    end
    read_enb = 3'b100;
    cyc();
    @(negedge clock);
    checks++;
    if (soft_reset !== 3'b000) begin
      errors++; $display("FAIL timeout_read_wins got=%b exp=%b", soft_reset, 3'b000);
    end
    read_enb = 3'b000;
    cyc();
    @(negedge clock);
    checks++;
    if (soft_reset !== 3'b000) begin
      errors++; $display("FAIL timeout_after_read got=%b exp=%b", soft_reset, 3'b000);
    end
    read_enb   = 3'b111;
    fifo_empty = 3'b111;
    cyc();
  endtask

  task automatic test_abort();
    fifo_empty = 3'b011;
    read_enb   = 3'b100;
    cyc();
    read_enb  = 3'b000;
    pkt_valid = 1'b1;
    data_in   = 8'h02;
    cyc();
    pkt_valid = 1'b0;
    for (int k = 2; k <= 30; k++) begin
      cyc();
    end
    @(negedge clock);
    checks++;
    if ({soft_reset, obs} !== {3'b100, O_WAIT}) begin
      errors++; $display("FAIL abort_pulse got=%b/%b exp=%b/%b", soft_reset, obs, 3'b100, O_WAIT);
    end
    cyc();
    @(negedge clock);
    checks++;
    if (obs !== O_DEC) begin
      errors++; $display("FAIL abort_to_decode got=%b exp=%b", obs, O_DEC);
    end
    read_enb   = 3'b111;
    fifo_empty = 3'b111;
    cyc();
  endtask

  task automatic test_addr3();
    pkt_valid = 1'b1;
    data_in   = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== O_DEC) begin
        errors++; $display("FAIL addr3_ignored%0d got=%b exp=%b", k, obs, O_DEC);
      end
      cyc();
    end
    pkt_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_packet();
    pkt_valid = 1'b1;
    data_in   = 8'h01;
    cyc();
    cyc();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== 9'b0_0_1_0_0_0_010) begin
      errors++; $display("FAIL rstmid_ld got=%b exp=%b", obs, 9'b0_0_1_0_0_0_010);
    end
    cyc();
    @(negedge clock);
    checks++;
    if (obs !== O_DEC) begin
      errors++; $display("FAIL rstmid_decode got=%b exp=%b", obs, O_DEC);
    end
    reset     = 1'b0;
    pkt_valid = 1'b0;
    cyc();
    @(negedge clock);
    checks++;
    if (obs !== O_DEC) begin
      errors++; $display("FAIL rstmid_stays got=%b exp=%b", obs, O_DEC);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    pkt_valid  = 1'b0;
    data_in    = 8'h00;
    fifo_full  = 3'b000;
    fifo_empty = 3'b111;
    read_enb   = 3'b111;
    test_reset();
    test_basic_packet();
    test_wait_empty();
    test_fifo_full();
    test_timeout();
    test_abort();
    test_addr3();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
